// File: rtl/cu_data_read_line_assembler_pkg.sv
// ---------------------------------------------------------------------------
// cu_data_read_line_assembler_pkg
// Shared types and constants for the CU data-read line assembler: half-line
// transport records, the assembled cacheline record, buffer status and the
// serialiser state encoding, plus small element helpers.
// ---------------------------------------------------------------------------
package cu_data_read_line_assembler_pkg;

  localparam int ELEM_BITS         = 32;
  localparam int HALF_LINE_BITS    = 512;
  localparam int CACHELINE_BITS    = 2 * HALF_LINE_BITS;
  localparam int ELEMENTS_PER_HALF = HALF_LINE_BITS / ELEM_BITS;
  localparam int ELEMENTS_PER_LINE = 2 * ELEMENTS_PER_HALF;
  localparam int ARRAY_SIZE_BITS   = 32;
  localparam int OFFSET_BITS       = 16;
  // n ranges 0..ELEMENTS_PER_LINE, idx ranges 0..ELEMENTS_PER_LINE-1
  localparam int ELEM_CNT_BITS     = $clog2(ELEMENTS_PER_LINE + 1);
  localparam int IDX_BITS          = $clog2(ELEMENTS_PER_LINE);

  typedef enum logic [1:0] {
    STRUCT_INVALID = 2'd0,
    READ_DATA      = 2'd1,
    WRITE_DATA     = 2'd2,
    STRUCT_OTHER   = 2'd3
  } array_struct_t;

  typedef struct packed {
    array_struct_t              array_struct;
    logic [OFFSET_BITS-1:0]     address_offest;
    logic [ARRAY_SIZE_BITS-1:0] real_size;
  } CommandTagLine;

  // data[HALF_LINE_BITS-1] is the first (most significant) bit of the half
  typedef struct packed {
    logic                      valid;
    CommandTagLine             cmd;
    logic [HALF_LINE_BITS-1:0] data;
  } ReadWriteDataLine;

  typedef struct packed {
    CommandTagLine             cmd;
    logic [CACHELINE_BITS-1:0] data;
    logic [ELEM_CNT_BITS-1:0]  n;
  } AssembledLine;

  typedef struct packed {
    logic empty;
    logic alfull;
    logic full;
  } BufferStatus;

  typedef enum logic [1:0] {
    SER_IDLE   = 2'd0,
    SER_LOAD   = 2'd1,
    SER_STREAM = 2'd2
  } ser_state_t;

  // Number of elements to emit from one line: min(real_size, elements per line)
  function automatic logic [ELEM_CNT_BITS-1:0] elem_count(input logic [ARRAY_SIZE_BITS-1:0] real_size);
    logic [ELEM_CNT_BITS-1:0] n;
    if (real_size >= ARRAY_SIZE_BITS'(ELEMENTS_PER_LINE)) begin
      n = ELEM_CNT_BITS'(ELEMENTS_PER_LINE);
    end else begin
      n = real_size[ELEM_CNT_BITS-1:0];
    end
    return n;
  endfunction

  // Element 0 is the most significant word of the line (first bit of data_0)
  function automatic logic [ELEM_BITS-1:0] line_element(input logic [CACHELINE_BITS-1:0] line,
                                                        input logic [IDX_BITS-1:0]       idx);
    return line[CACHELINE_BITS-1-int'(idx)*ELEM_BITS -: ELEM_BITS];
  endfunction

endpackage

// File: rtl/cu_half_line_fifo.sv
// ---------------------------------------------------------------------------
// cu_half_line_fifo
// Synchronous FIFO of half-line records with occupancy tracking.
// Ports:
//   clock, rstn      clock and asynchronous active-high reset
//   push, push_data  write request and record
//   pop              read request (ignored when empty)
//   head             record at the FIFO head (valid when !empty)
//   empty/full/alfull occupancy flags; alfull when count >= DEPTH-ALFULL_MARGIN
//   overflow         pulse: push dropped because FIFO full and not popping
// ---------------------------------------------------------------------------
module cu_half_line_fifo
  import cu_data_read_line_assembler_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int ALFULL_MARGIN = 4
) (
  input  logic             clock,
  input  logic             rstn,
  input  logic             push,
  input  ReadWriteDataLine push_data,
  input  logic             pop,
  output ReadWriteDataLine head,
  output logic             empty,
  output logic             full,
  output logic             alfull,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL   = (AW+1)'(DEPTH);
  localparam logic [AW:0] ALFULL_LEVEL = (AW+1)'(DEPTH - ALFULL_MARGIN);

  ReadWriteDataLine mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_pop   = pop & ~empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is legal then
  assign do_push  = push & (~full | do_pop);
  assign overflow = push & full & ~do_pop;

  assign empty  = (count == '0);
  assign full   = (count == FULL_LEVEL);
  assign alfull = (count >= ALFULL_LEVEL);
  assign head   = mem[rd_ptr];

  // storage array; contents need no reset since pointers define validity
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // pointer and occupancy bookkeeping
  always_ff @(posedge clock or posedge rstn) begin
    if (rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cu_data_read_line_assembler.sv
// ---------------------------------------------------------------------------
// cu_data_read_line_assembler
// Pairs the two 512-bit half-line streams of READ_DATA responses into
// 1024-bit cachelines and serialises up to real_size 32-bit elements per
// line onto a ready/valid stream. Also counts delivered elements and
// reports half-FIFO status upstream as read data-out backpressure.
// Ports:
//   clock, rstn              clock and asynchronous active-high reset
//   enabled_in               CU enable (registered once)
//   total_elements_in        job size used for job_done_out
//   read_data_0_in/_1_in     first/second half-line inputs
//   stream_ready_in          consumer ready
//   stream_valid_out/_data_out/_last_out  element stream
//   data_buffer_status       {empty, alfull, full} of the half FIFOs
//   elements_done_out        elements accepted (saturating)
//   job_done_out             sticky: elements_done == total != 0
//   pair_error_out           sticky: head tag mismatch or FIFO overflow
// ---------------------------------------------------------------------------
module cu_data_read_line_assembler
  import cu_data_read_line_assembler_pkg::*;
#(
  parameter int HALF_FIFO_DEPTH = 16,
  parameter int ALFULL_MARGIN   = 4
) (
  input  logic                       clock,
  input  logic                       rstn,
  input  logic                       enabled_in,
  input  logic [ARRAY_SIZE_BITS-1:0] total_elements_in,
  input  ReadWriteDataLine           read_data_0_in,
  input  ReadWriteDataLine           read_data_1_in,
  input  logic                       stream_ready_in,
  output logic                       stream_valid_out,
  output logic [ELEM_BITS-1:0]       stream_data_out,
  output logic                       stream_last_out,
  output BufferStatus                data_buffer_status,
  output logic [ARRAY_SIZE_BITS-1:0] elements_done_out,
  output logic                       job_done_out,
  output logic                       pair_error_out
);

  logic             enabled;
  ReadWriteDataLine cap_0;
  ReadWriteDataLine cap_1;

  ReadWriteDataLine head_0;
  ReadWriteDataLine head_1;
  logic             empty_0, empty_1, full_0, full_1, alfull_0, alfull_1, ovf_0, ovf_1;

  ser_state_t               state, state_next;
  AssembledLine             line, line_next, incoming;
  logic [IDX_BITS-1:0]      idx, idx_next, idx_plus;
  logic                     valid_q, valid_next;
  logic [ELEM_BITS-1:0]     data_q, data_next;
  logic                     last_q, last_next;

  logic                       xfer, can_load, pair, tag_mismatch;
  logic [ARRAY_SIZE_BITS-1:0] elements_done;
  logic                       job_done, pair_error;
  BufferStatus                status;
  logic                       unused_fields;

  // register the enable and qualify incoming halves (READ_DATA only)
  always_ff @(posedge clock or posedge rstn) begin
    if (rstn) begin
      enabled <= 1'b0;
      cap_0   <= '0;
      cap_1   <= '0;
    end else begin
      enabled     <= enabled_in;
      cap_0       <= read_data_0_in;
      cap_1       <= read_data_1_in;
      cap_0.valid <= enabled & read_data_0_in.valid & (read_data_0_in.cmd.array_struct == READ_DATA);
      cap_1.valid <= enabled & read_data_1_in.valid & (read_data_1_in.cmd.array_struct == READ_DATA);
    end
  end

  cu_half_line_fifo #(.DEPTH(HALF_FIFO_DEPTH), .ALFULL_MARGIN(ALFULL_MARGIN)) u_fifo_0 (
    .clock(clock), .rstn(rstn), .push(cap_0.valid), .push_data(cap_0), .pop(pair),
    .head(head_0), .empty(empty_0), .full(full_0), .alfull(alfull_0), .overflow(ovf_0)
  );

  cu_half_line_fifo #(.DEPTH(HALF_FIFO_DEPTH), .ALFULL_MARGIN(ALFULL_MARGIN)) u_fifo_1 (
    .clock(clock), .rstn(rstn), .push(cap_1.valid), .push_data(cap_1), .pop(pair),
    .head(head_1), .empty(empty_1), .full(full_1), .alfull(alfull_1), .overflow(ovf_1)
  );

  // Half 0 supplies the tag even when the heads disagree
  assign incoming     = {head_0.cmd, head_0.data, head_1.data, elem_count(head_0.cmd.real_size)};
  assign xfer         = enabled & valid_q & stream_ready_in;
  // A line with n==0 sitting in LOAD is discarded, so the next pair may replace it
  assign can_load     = (state == SER_IDLE) |
                        ((state == SER_STREAM) & xfer & last_q) |
                        ((state == SER_LOAD) & (line.n == '0));
  assign pair         = enabled & ~empty_0 & ~empty_1 & can_load;
  assign tag_mismatch = pair & (head_0.cmd.address_offest != head_1.cmd.address_offest);
  assign idx_plus     = idx + IDX_BITS'(1);
  assign unused_fields = ^{head_0.valid, head_1.valid, head_1.cmd.array_struct,
                           head_1.cmd.real_size, line.cmd};

  // serialiser next-state and registered-output computation
  always_comb begin
    state_next = state;
    line_next  = line;
    idx_next   = idx;
    valid_next = valid_q;
    data_next  = data_q;
    last_next  = last_q;
    if (enabled) begin
      case (state)
        SER_IDLE: begin
          if (pair) begin
            state_next = SER_LOAD;
            line_next  = incoming;
          end else begin
            state_next = SER_IDLE;
          end
        end
        SER_LOAD: begin
          if (line.n == '0) begin
            if (pair) begin
              state_next = SER_LOAD;
              line_next  = incoming;
            end else begin
              state_next = SER_IDLE;
            end
          end else begin
            state_next = SER_STREAM;
            idx_next   = '0;
            valid_next = 1'b1;
            data_next  = line_element(line.data, IDX_BITS'(0));
            last_next  = (line.n == ELEM_CNT_BITS'(1));
          end
        end
        SER_STREAM: begin
          if (xfer) begin
            if (last_q) begin
              if (pair && (incoming.n != '0)) begin
                // start the next line directly so lines stream without a bubble
                state_next = SER_STREAM;
                line_next  = incoming;
                idx_next   = '0;
                valid_next = 1'b1;
                data_next  = line_element(incoming.data, IDX_BITS'(0));
                last_next  = (incoming.n == ELEM_CNT_BITS'(1));
              end else if (pair) begin
                state_next = SER_LOAD;
                line_next  = incoming;
                valid_next = 1'b0;
                data_next  = '0;
                last_next  = 1'b0;
              end else begin
                state_next = SER_IDLE;
                valid_next = 1'b0;
                data_next  = '0;
                last_next  = 1'b0;
              end
            end else begin
              idx_next  = idx_plus;
              data_next = line_element(line.data, idx_plus);
              last_next = ({1'b0, idx_plus} == (line.n - ELEM_CNT_BITS'(1)));
            end
          end else begin
            state_next = SER_STREAM;
          end
        end
        default: begin
          state_next = SER_IDLE;
          valid_next = 1'b0;
          data_next  = '0;
          last_next  = 1'b0;
        end
      endcase
    end else begin
      state_next = state;
    end
  end

  // serialiser state register
  always_ff @(posedge clock or posedge rstn) begin
    if (rstn) begin
      state   <= SER_IDLE;
      line    <= '0;
      idx     <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state   <= state_next;
      line    <= line_next;
      idx     <= idx_next;
      valid_q <= valid_next;
      data_q  <= data_next;
      last_q  <= last_next;
    end
  end

  // delivered-element counter, job completion, sticky error and buffer status
  always_ff @(posedge clock or posedge rstn) begin
    if (rstn) begin
      elements_done <= '0;
      job_done      <= 1'b0;
      pair_error    <= 1'b0;
      status        <= '{empty: 1'b1, alfull: 1'b0, full: 1'b0};
    end else begin
      if (xfer && (elements_done != '1)) begin
        elements_done <= elements_done + ARRAY_SIZE_BITS'(1);
      end
      job_done   <= job_done | ((elements_done == total_elements_in) && (total_elements_in != '0));
      pair_error <= pair_error | tag_mismatch | ovf_0 | ovf_1;
      status     <= '{empty:  empty_0 & empty_1,
                      alfull: alfull_0 | alfull_1,
                      full:   full_0 | full_1};
    end
  end

  assign stream_valid_out   = valid_q;
  assign stream_data_out    = data_q;
  assign stream_last_out    = last_q;
  assign data_buffer_status = status;
  assign elements_done_out  = elements_done;
  assign job_done_out       = job_done;
  assign pair_error_out     = pair_error;

endmodule

// File: tb/tb_cu_data_read_line_assembler.sv
// Directed bench for cu_data_read_line_assembler. Expected elements are
// derived from the lines the bench itself builds: element k of a line is
// the k-th 32-bit word counting from the first (most significant) bit of
// data_0.
module tb_cu_data_read_line_assembler;
  import cu_data_read_line_assembler_pkg::*;

  logic                       clock = 1'b0;
  logic                       rstn  = 1'b1;
  logic                       enabled_in = 1'b1;
  logic [ARRAY_SIZE_BITS-1:0] total_elements_in = '0;
  ReadWriteDataLine           read_data_0_in = '0;
  ReadWriteDataLine           read_data_1_in = '0;
  logic                       stream_ready_in = 1'b1;
  logic                       stream_valid_out;
  logic [ELEM_BITS-1:0]       stream_data_out;
  logic                       stream_last_out;
  BufferStatus                data_buffer_status;
  logic [ARRAY_SIZE_BITS-1:0] elements_done_out;
  logic                       job_done_out;
  logic                       pair_error_out;

  int checks = 0;
  int fails  = 0;
  logic [1023:0] lines [4];

  cu_data_read_line_assembler dut (
    .clock(clock), .rstn(rstn), .enabled_in(enabled_in), .total_elements_in(total_elements_in),
    .read_data_0_in(read_data_0_in), .read_data_1_in(read_data_1_in),
    .stream_ready_in(stream_ready_in), .stream_valid_out(stream_valid_out),
    .stream_data_out(stream_data_out), .stream_last_out(stream_last_out),
    .data_buffer_status(data_buffer_status), .elements_done_out(elements_done_out),
    .job_done_out(job_done_out), .pair_error_out(pair_error_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1023:0] make_line(input logic [31:0] base);
    logic [1023:0] l;
    l = '0;
    for (int k = 0; k < 32; k++) l[1023-32*k -: 32] = base + 32'(k);
    return l;
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b1;
    step(2);
    rstn = 1'b0;
    step(1);
  endtask

  task automatic push_halves(input bit v0, input bit v1, input logic [1023:0] ln,
                             input logic [15:0] off0, input logic [15:0] off1, input logic [31:0] rs);
    read_data_0_in.valid = v0;
    read_data_0_in.cmd.array_struct = READ_DATA;
    read_data_0_in.cmd.address_offest = off0;
    read_data_0_in.cmd.real_size = rs;
    read_data_0_in.data = ln[1023:512];
    read_data_1_in.valid = v1;
    read_data_1_in.cmd.array_struct = READ_DATA;
    read_data_1_in.cmd.address_offest = off1;
    read_data_1_in.cmd.real_size = rs;
    read_data_1_in.data = ln[511:0];
    step(1);
    read_data_0_in.valid = 1'b0;
    read_data_1_in.valid = 1'b0;
  endtask

  // Called right after the last half is captured: output stays idle while the
  // half is written and the line loaded, then the first element appears.
  task automatic expect_latency(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_idle"}, 64'(stream_valid_out), 64'd0);
      step(1);
    end
    chk({tag, "_first_valid"}, 64'(stream_valid_out), 64'd1);
  endtask

  task automatic stream_check(input int n, input int stop_after, input bit toggle,
                              input int budget, output int got, output int gaps);
    bit rdy, have_held, started;
    logic [31:0] held, exp;
    int li, k;
    got = 0; gaps = 0; rdy = 1'b0; have_held = 1'b0; started = 1'b0; held = '0;
    for (int c = 0; c < budget && got < stop_after; c++) begin
      rdy = toggle ? ~rdy : 1'b1;
      stream_ready_in = rdy;
      if (stream_valid_out) begin
        started = 1'b1;
        li  = got / n;
        k   = got % n;
        exp = lines[li][1023-32*k -: 32];
        if (have_held) chk("hold_data", 64'(stream_data_out), 64'(held));
        if (rdy) begin
          chk("elem_data", 64'(stream_data_out), 64'(exp));
          chk("elem_last", 64'(stream_last_out), 64'(k == n - 1));
          got++;
          have_held = 1'b0;
        end else begin
          held = stream_data_out;
          have_held = 1'b1;
        end
      end else if (started) begin
        gaps++;
      end
      step(1);
    end
    stream_ready_in = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int got, gaps;
    // --- reset state
    do_reset();
    chk("rst_valid", 64'(stream_valid_out), 64'd0);
    chk("rst_data", 64'(stream_data_out), 64'd0);
    chk("rst_last", 64'(stream_last_out), 64'd0);
    chk("rst_status", 64'(data_buffer_status), 64'b100);
    chk("rst_done", 64'(elements_done_out), 64'd0);
    chk("rst_job", 64'(job_done_out), 64'd0);
    chk("rst_err", 64'(pair_error_out), 64'd0);

    // --- single full line, elements 0..31
    total_elements_in = 32'd32;
    lines[0] = make_line(32'h0000_0000);
    push_halves(1'b1, 1'b1, lines[0], 16'h0, 16'h0, 32'd32);
    expect_latency("t1");
    stream_check(32, 32, 1'b0, 40, got, gaps);
    chk("t1_count", 64'(got), 64'd32);
    chk("t1_after_valid", 64'(stream_valid_out), 64'd0);
    chk("t1_done", 64'(elements_done_out), 64'd32);
    step(1);
    chk("t1_job", 64'(job_done_out), 64'd1);
    chk("t1_err", 64'(pair_error_out), 64'd0);

    // --- partial line, half 1 three cycles late
    do_reset();
    lines[0] = make_line(32'hA000_0000);
    push_halves(1'b1, 1'b0, lines[0], 16'h40, 16'h40, 32'd5);
    chk("t2_wait0", 64'(stream_valid_out), 64'd0);
    step(1);
    chk("t2_wait1", 64'(stream_valid_out), 64'd0);
    step(1);
    push_halves(1'b0, 1'b1, lines[0], 16'h40, 16'h40, 32'd5);
    expect_latency("t2");
    stream_check(5, 5, 1'b0, 20, got, gaps);
    chk("t2_count", 64'(got), 64'd5);
    chk("t2_after_valid", 64'(stream_valid_out), 64'd0);
    chk("t2_done", 64'(elements_done_out), 64'd5);
    step(1);
    chk("t2_job", 64'(job_done_out), 64'd0);

    // --- four lines back to back
    do_reset();
    total_elements_in = 32'd128;
    for (int i = 0; i < 4; i++) lines[i] = make_line(32'(i + 1) << 16);
    for (int i = 0; i < 4; i++) push_halves(1'b1, 1'b1, lines[i], 16'(i * 128), 16'(i * 128), 32'd32);
    stream_check(32, 128, 1'b0, 160, got, gaps);
    chk("t3_count", 64'(got), 64'd128);
    chk("t3_gaps", 64'(gaps), 64'd0);
    chk("t3_done", 64'(elements_done_out), 64'd128);
    step(1);
    chk("t3_job", 64'(job_done_out), 64'd1);

    // --- ready toggling 1010...
    do_reset();
    lines[0] = make_line(32'h5A5A_0000);
    push_halves(1'b1, 1'b1, lines[0], 16'h0, 16'h0, 32'd32);
    stream_check(32, 32, 1'b1, 100, got, gaps);
    chk("t4_count", 64'(got), 64'd32);
    chk("t4_done", 64'(elements_done_out), 64'd32);

    // --- tag mismatch still streams the line
    do_reset();
    chk("t5_err_before", 64'(pair_error_out), 64'd0);
    lines[0] = make_line(32'h0C00_0000);
    push_halves(1'b1, 1'b1, lines[0], 16'h0, 16'h80, 32'd8);
    stream_check(8, 8, 1'b0, 30, got, gaps);
    chk("t5_count", 64'(got), 64'd8);
    chk("t5_err", 64'(pair_error_out), 64'd1);

    // --- reset in the middle of streaming, with a second line queued
    do_reset();
    lines[0] = make_line(32'h7700_0000);
    lines[1] = make_line(32'h7800_0000);
    push_halves(1'b1, 1'b1, lines[0], 16'h0, 16'h0, 32'd32);
    push_halves(1'b1, 1'b1, lines[1], 16'h80, 16'h80, 32'd32);
    stream_check(32, 10, 1'b0, 30, got, gaps);
    chk("t6_pre_idx10", 64'(stream_data_out), 64'h7700_000A);
    chk("t6_pre_done", 64'(elements_done_out), 64'd10);
    rstn = 1'b1;
    step(1);
    chk("t6_valid", 64'(stream_valid_out), 64'd0);
    chk("t6_data", 64'(stream_data_out), 64'd0);
    chk("t6_last", 64'(stream_last_out), 64'd0);
    chk("t6_done", 64'(elements_done_out), 64'd0);
    chk("t6_status", 64'(data_buffer_status), 64'b100);
    rstn = 1'b0;
    step(6);
    chk("t6_no_replay", 64'(stream_valid_out), 64'd0);
    chk("t6_status_after", 64'(data_buffer_status), 64'b100);

    // --- fill port 0 only: almost-full threshold and overflow
    do_reset();
    stream_ready_in = 1'b0;
    lines[0] = make_line(32'h1234_0000);
    for (int i = 0; i < 11; i++) push_halves(1'b1, 1'b0, lines[0], 16'h0, 16'h0, 32'd32);
    step(2);
    chk("t7_alfull_11", 64'(data_buffer_status), 64'b000);
    push_halves(1'b1, 1'b0, lines[0], 16'h0, 16'h0, 32'd32);
    step(2);
    chk("t7_alfull_12", 64'(data_buffer_status), 64'b010);
    for (int i = 0; i < 4; i++) push_halves(1'b1, 1'b0, lines[0], 16'h0, 16'h0, 32'd32);
    step(2);
    chk("t7_full_16", 64'(data_buffer_status), 64'b011);
    chk("t7_err_16", 64'(pair_error_out), 64'd0);
    push_halves(1'b1, 1'b0, lines[0], 16'h0, 16'h0, 32'd32);
    step(2);
    chk("t7_err_17", 64'(pair_error_out), 64'd1);
    chk("t7_full_17", 64'(data_buffer_status), 64'b011);
    stream_ready_in = 1'b1;

    // --- disabled: inputs ignored
    do_reset();
    enabled_in = 1'b0;
    step(2);
    lines[0] = make_line(32'h0BAD_0000);
    push_halves(1'b1, 1'b1, lines[0], 16'h0, 16'h0, 32'd32);
    step(6);
    chk("t8_valid", 64'(stream_valid_out), 64'd0);
    chk("t8_status", 64'(data_buffer_status), 64'b100);
    enabled_in = 1'b1;
    step(6);
    chk("t8_valid_reen", 64'(stream_valid_out), 64'd0);
    chk("t8_done", 64'(elements_done_out), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
